// File: rtl/fpuprod64_seq.sv
// fpuprod64_seq: issue sequencer and result buffer around the fpuprod64
// multiplier. One request is held in an operand register and issued once
// (high half) or twice (high then low half). Because the multiplier cannot
// stall, an op is issued only when a FIFO slot is already reserved for its
// result. Results return after a fixed 2-cycle latency, tracked by a tagged
// valid pipeline.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload until the transfer. in_ready
// is a function of the FSM state and reset only, never of in_valid.
// out_valid and the head payload stay stable until popped.
module fpuprod64_seq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_A,
    input  logic [63:0]      in_B,
    input  logic             in_rnd,
    input  logic             in_full,
    input  logic [TAG_W-1:0] in_tag,
    output logic [63:0]      mul_A,
    output logic [63:0]      mul_B,
    output logic             mul_rnd,
    output logic             mul_pookg,
    input  logic [63:0]      mul_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_lo,
    output logic [1:0]       dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand register: the one request currently being issued
    logic [63:0]      op_a, op_b;
    logic             op_rnd, op_full;
    logic [TAG_W-1:0] op_tag;

    // Last issued operands, so mul_A/B/rnd hold between issues
    logic [63:0] last_a, last_b;
    logic        last_rnd;

    // Two-stage tag pipeline matching the multiplier latency
    logic             p1_v, p2_v;
    logic [TAG_W-1:0] p1_tag, p2_tag;
    logic             p1_lo, p2_lo;

    // Result FIFO
    logic [63:0]      fifo_res [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic             fifo_lo  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;

    logic             accept, issue, issue_lo, credit, push, pop;
    logic [1:0]       inflight;
    logic [PTR_W+1:0] occupancy;

    assign in_ready  = !rst && (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state_q;

    // Reserved slots: results already buffered plus every op still in the
    // multiplier (stage 2 is the one being captured this cycle). Using only
    // registered values means a same-cycle pop never creates credit.
    assign inflight  = {1'b0, p1_v} + {1'b0, p2_v};
    assign occupancy = {1'b0, fifo_count} + {{PTR_W{1'b0}}, inflight};
    assign credit    = occupancy < (PTR_W+2)'(DEPTH);

    assign push      = p2_v;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    // Next-state and issue decision
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        issue_lo = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) state_d = S_HI;
                end
                S_HI: begin
                    if (credit) begin
                        issue   = 1'b1;
                        state_d = op_full ? S_LO : S_IDLE;
                    end
                end
                S_LO: begin
                    if (credit) begin
                        issue    = 1'b1;
                        issue_lo = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Multiplier operands: live operand register on an issue, else last issue
    always_comb begin
        mul_A     = issue ? op_a   : last_a;
        mul_B     = issue ? op_b   : last_b;
        mul_rnd   = issue ? op_rnd : last_rnd;
        mul_pookg = issue_lo;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Operand register loads on accept; last-issue registers load on issue
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_rnd   <= 1'b0;
            op_full  <= 1'b0;
            op_tag   <= '0;
            last_a   <= '0;
            last_b   <= '0;
            last_rnd <= 1'b0;
        end else begin
            if (accept) begin
                op_a    <= in_A;
                op_b    <= in_B;
                op_rnd  <= in_rnd;
                op_full <= in_full;
                op_tag  <= in_tag;
            end
            if (issue) begin
                last_a   <= op_a;
                last_b   <= op_b;
                last_rnd <= op_rnd;
            end
        end
    end

    // Tag pipeline shifts every cycle; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_v   <= 1'b0;
            p1_tag <= '0;
            p1_lo  <= 1'b0;
            p2_v   <= 1'b0;
            p2_tag <= '0;
            p2_lo  <= 1'b0;
        end else begin
            p1_v   <= issue;
            p1_tag <= op_tag;
            p1_lo  <= issue_lo;
            p2_v   <= p1_v;
            p2_tag <= p1_tag;
            p2_lo  <= p1_lo;
        end
    end

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_res[i] <= '0;
                fifo_tag[i] <= '0;
                fifo_lo[i]  <= 1'b0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_res[wr_ptr] <= mul_res;
                fifo_tag[wr_ptr] <= p2_tag;
                fifo_lo[wr_ptr]  <= p2_lo;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head of FIFO drives the result outputs
    always_comb begin
        out_res = fifo_res[rd_ptr];
        out_tag = fifo_tag[rd_ptr];
        out_lo  = fifo_lo[rd_ptr];
    end

endmodule

// File: tb/tb_fpuprod64_seq.sv
// Testbench for fpuprod64_seq: a behavioural fpuprod64 stand-in with 2-cycle
// latency, directed tests with literal values, randomized traffic, and an
// in-order scoreboard of expected {lo, tag, res} results.
module tb_fpuprod64_seq;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int W     = 64 + TAG_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_rnd, in_full;
    logic [63:0]      in_A, in_B;
    logic [TAG_W-1:0] in_tag;
    logic [63:0]      mul_A, mul_B, mul_res;
    logic             mul_rnd, mul_pookg;
    logic             out_valid, out_ready, out_lo;
    logic [63:0]      out_res;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int acc_count = 0;
    logic rand_ready = 1'b0;
    logic ready_force = 1'b1;
    logic [W-1:0] exp_q[$];

    fpuprod64_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_rnd(in_rnd), .in_full(in_full),
        .in_tag(in_tag), .mul_A(mul_A), .mul_B(mul_B), .mul_rnd(mul_rnd),
        .mul_pookg(mul_pookg), .mul_res(mul_res), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
        .out_lo(out_lo), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference multiplier ----------------
    // Significands are {1, frac[52:0]}; high half is the normalised top 53
    // fraction bits, low half carries the bottom 53 product bits at exp-53.
    function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic rnd, input logic lo);
        logic [107:0] p;
        logic [9:0]   e;
        logic [52:0]  f;
        logic         s;
        s = a[63] ^ b[63];
        p = {54'd0, 1'b1, a[52:0]} * {54'd0, 1'b1, b[52:0]};
        e = a[62:53] + b[62:53] - 10'h200 + (p[107] ? 10'd1 : 10'd0);
        if (!lo) f = p[107] ? p[106:54] : p[105:53];
        else begin
            e = e - 10'd53;
            f = p[52:0];
        end
        return {s, e, f} ^ {63'd0, rnd};
    endfunction

    logic [63:0] st1, st2;
    always @(posedge clk) begin
        st1 <= mul_model(mul_A, mul_B, mul_rnd, mul_pookg);
        st2 <= st1;
    end
    assign mul_res = st2;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // out_ready owner: forced level or random per cycle
    always begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // ---------------- scoreboard: accept, pop, hold, occupancy ----------------
    logic             hold_prev = 1'b0;
    logic [W-1:0]     hold_val;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                acc_count++;
                exp_q.push_back({1'b0, in_tag, mul_model(in_A, in_B, in_rnd, 1'b0)});
                if (in_full)
                    exp_q.push_back({1'b1, in_tag, mul_model(in_A, in_B, in_rnd, 1'b1)});
            end
            if (hold_prev)
                check("hold_stable", {out_valid, out_lo, out_tag, out_res}, {1'b1, hold_val});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_result", {out_lo, out_tag, out_res}, '1);
                else
                    check("result", {out_lo, out_tag, out_res}, exp_q.pop_front());
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = {out_lo, out_tag, out_res};
            check("fifo_count_le_depth", 128'(dut.fifo_count <= DEPTH), 128'(1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic rnd,
                        input logic full, input logic [TAG_W-1:0] tag);
        int n = 0;
        in_A = a; in_B = b; in_rnd = rnd; in_full = full; in_tag = tag;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                fail_now("send_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(negedge clk);
        check("empty_after_drain", 128'(out_valid), 128'(0));
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid || n > 20) break;
            n++;
        end
        if (!out_valid) fail_now(name);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a0, a1, k;
        logic took;
        rst = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; in_rnd = 1'b0;
        in_full = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", 128'(in_ready), 128'(0));
        check("pookg_in_reset", 128'(mul_pookg), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out", {out_valid, out_lo, out_tag, out_res}, '0);
        check("rst_mul", {mul_A, mul_B, mul_rnd, mul_pookg}, '0);

        // model pinned by hand-computed values
        check("model_2x3", mul_model(64'h4020000000000000, 64'h4030000000000000, 1'b0, 1'b0),
              64'h4050000000000000);
        check("model_1x1_lo", mul_model(64'h4000000000000000, 64'h4000000000000000, 1'b0, 1'b1),
              64'h3960000000000000);

        // 2.0 x 3.0, latency from accept
        @(posedge clk); #1;
        send(64'h4020000000000000, 64'h4030000000000000, 1'b0, 1'b0, 4'd5);
        a0 = acc_cyc;
        wait_out_valid("latency_timeout");
        check("latency", 128'(cyc - a0), 128'(4));
        check("res_2x3", {out_lo, out_tag, out_res}, {1'b0, 4'd5, 64'h4050000000000000});
        drain();

        // full mode 1.0 x 1.0: high then low on consecutive cycles
        @(posedge clk); #1;
        send(64'h4000000000000000, 64'h4000000000000000, 1'b0, 1'b1, 4'd2);
        wait_out_valid("full_timeout");
        check("full_hi", {out_lo, out_tag, out_res}, {1'b0, 4'd2, 64'h4000000000000000});
        @(negedge clk);
        check("full_lo", {out_valid, out_lo, out_tag, out_res},
              {1'b1, 1'b1, 4'd2, 64'h3960000000000000});
        drain();

        // throughput: singles every 2 cycles, full requests every 3
        @(posedge clk); #1;
        send(64'h4020000000000000, 64'h4020000000000000, 1'b0, 1'b0, 4'd1);
        a0 = acc_cyc;
        send(64'h4030000000000000, 64'h4020000000000000, 1'b1, 1'b0, 4'd3);
        a1 = acc_cyc;
        check("single_spacing", 128'(a1 - a0), 128'(2));
        send(64'hC031000000000000, 64'h4027000000000123, 1'b0, 1'b1, 4'd6);
        a0 = acc_cyc;
        send(64'h4035555555555555, 64'h4011111111111111, 1'b1, 1'b1, 4'd7);
        a1 = acc_cyc;
        check("full_spacing", 128'(a1 - a0), 128'(3));
        drain();

        // FIFO wrap: 3*DEPTH singles with random out_ready
        rand_ready = 1'b1;
        for (int t = 0; t < 3 * DEPTH; t++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'b0, TAG_W'(t));
        drain();

        // random mix of single and full requests
        for (int t = 0; t < 24; t++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)));
        drain();
        rand_ready = 1'b0;

        // backpressure: DEPTH issued, one more held in the operand register
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a0 = acc_count;
        k = 0;
        in_A = {$urandom, $urandom}; in_B = {$urandom, $urandom};
        in_rnd = 1'b0; in_full = 1'b0; in_tag = TAG_W'(k);
        in_valid = 1'b1;
        repeat (30) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                k++;
                in_A = {$urandom, $urandom}; in_B = {$urandom, $urandom};
                in_tag = TAG_W'(k);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepts", 128'(acc_count - a0), 128'(DEPTH + 1));
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_buffered", 128'(dut.fifo_count), 128'(DEPTH));
        ready_force = 1'b1;
        drain();

        // reset one cycle after issuing a full request
        @(posedge clk); #1;
        send(64'h4000000000000000, 64'h4000000000000000, 1'b0, 1'b1, 4'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pookg", 128'(mul_pookg), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("no_valid_after_rst", 128'(out_valid), 128'(0));
        end
        @(posedge clk); #1;
        send(64'h4020000000000000, 64'h4030000000000000, 1'b0, 1'b0, 4'd9);
        wait_out_valid("post_rst_timeout");
        check("post_rst_res", {out_lo, out_tag, out_res}, {1'b0, 4'd9, 64'h4050000000000000});
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
